// File: rtl/luma_frame_stats.sv
// luma_frame_stats: per-frame luma count/sum/min/max with a sequential mean divider and contrast-curve select
// Ports: clk, rst (async, active-high); per_frame_vsync/href/clken + per_img_Y input stream;
//        frame_mean/min/max, curve_sel, frame_empty outputs for the last completed frame;
//        stats_valid one-cycle update pulse; busy while the divider runs.
module luma_frame_stats #(
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic [7:0] frame_mean,
  output logic [7:0] frame_min,
  output logic [7:0] frame_max,
  output logic [2:0] curve_sel,
  output logic       frame_empty,
  output logic       stats_valid,
  output logic       busy
);
  localparam int SUM_W = CNT_W + 8;
  localparam int BW = $clog2(SUM_W);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_n;
  logic v_d, seen, vs_edge, q, ge, last;
  logic [CNT_W-1:0] cnt, cnt_n, dvs, rem;
  logic [CNT_W:0] rem_sh, diff;
  logic [SUM_W-1:0] sum, sum_n, dvd;
  logic [7:0] mn, mx, mn_n, mx_n, hmin, hmax, quo, quo_n, spread;
  logic [BW-1:0] bit_cnt;
  always_comb begin
    q = per_frame_href & per_frame_clken;
    vs_edge = per_frame_vsync & ~v_d;
    cnt_n = q && !(&cnt) ? cnt + CNT_W'(1) : cnt;
    sum_n = q && !(&cnt) ? sum + SUM_W'(per_img_Y) : sum;
    mn_n = q && per_img_Y < mn ? per_img_Y : mn;
    mx_n = q && per_img_Y > mx ? per_img_Y : mx;
    rem_sh = {rem, dvd[SUM_W-1]};
    diff = rem_sh - {1'b0, dvs};
    // remainder stays below the divisor, so a borrow in the top bit means rem_sh < dvs
    ge = !diff[CNT_W];
    quo_n = {quo[6:0], ge};
    last = bit_cnt == BW'(SUM_W - 1);
    spread = hmax - hmin;
  end
  always_comb begin
    state_n = state;
    if (vs_edge && seen) state_n = cnt_n == '0 ? DONE : DIV;
    else if (state == DIV) state_n = last ? DONE : DIV;
    else if (state == DONE) state_n = IDLE;
  end
  assign busy = state == DIV;
  assign stats_valid = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_d <= 1'b0;
      seen <= 1'b0;
      cnt <= '0;
      sum <= '0;
      mn <= 8'hFF;
      mx <= 8'h00;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      bit_cnt <= '0;
      hmin <= '0;
      hmax <= '0;
      frame_mean <= '0;
      frame_min <= '0;
      frame_max <= '0;
      curve_sel <= '0;
      frame_empty <= 1'b0;
    end else begin
      v_d <= per_frame_vsync;
      if (vs_edge) begin
        seen <= 1'b1;
        cnt <= '0;
        sum <= '0;
        mn <= 8'hFF;
        mx <= 8'h00;
        if (seen) begin
          dvd <= sum_n;
          dvs <= cnt_n;
          rem <= '0;
          quo <= '0;
          bit_cnt <= '0;
          hmin <= mn_n;
          hmax <= mx_n;
          if (cnt_n == '0) begin
            frame_mean <= '0;
            frame_min <= '0;
            frame_max <= '0;
            curve_sel <= 3'd7;
            frame_empty <= 1'b1;
          end
        end
      end else begin
        cnt <= cnt_n;
        sum <= sum_n;
        mn <= mn_n;
        mx <= mx_n;
        if (state == DIV) begin
          dvd <= {dvd[SUM_W-2:0], 1'b0};
          rem <= ge ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
          quo <= quo_n;
          bit_cnt <= bit_cnt + BW'(1);
          // results land on the clock entering DONE so they are visible with stats_valid
          if (last) begin
            frame_mean <= quo_n;
            frame_min <= hmin;
            frame_max <= hmax;
            curve_sel <= 3'd7 - spread[7:5];
            frame_empty <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_luma_frame_stats.sv
// tb_luma_frame_stats: directed checks of luma_frame_stats at CNT_W=20 and CNT_W=4
module tb_luma_frame_stats;
  logic clk = 0, rst = 0, vsync = 0, href = 0, clken = 0;
  logic [7:0] y = 0;
  logic [7:0] mean0, min0, max0, mean1, min1, max1;
  logic [2:0] cs0, cs1;
  logic emp0, emp1, sv0, sv1, busy0, busy1;
  int tests = 0, fails = 0;
  int lat, pulses;
  always #5 clk = ~clk;
  luma_frame_stats #(.CNT_W(20)) dut (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Y(y), .frame_mean(mean0), .frame_min(min0),
    .frame_max(max0), .curve_sel(cs0), .frame_empty(emp0), .stats_valid(sv0), .busy(busy0)
  );
  luma_frame_stats #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Y(y), .frame_mean(mean1), .frame_min(min1),
    .frame_max(max1), .curve_sel(cs1), .frame_empty(emp1), .stats_valid(sv1), .busy(busy1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input bit sel, input string t, input logic [7:0] m, input logic [7:0] lo,
                         input logic [7:0] hi, input logic [2:0] c, input logic e);
    check({t, ".mean"}, sel ? mean1 : mean0, m);
    check({t, ".min"}, sel ? min1 : min0, lo);
    check({t, ".max"}, sel ? max1 : max0, hi);
    check({t, ".curve"}, sel ? cs1 : cs0, c);
    check({t, ".empty"}, sel ? emp1 : emp0, e);
  endtask
  task automatic pix(input logic [7:0] v);
    @(negedge clk);
    href = 1; clken = 1; y = v;
  endtask
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 0; clken = 0;
    end
  endtask
  task automatic do_edge(input bit px, input logic [7:0] v);
    @(negedge clk);
    vsync = 1; href = px; clken = px; y = v;
  endtask
  task automatic wait_valid(input bit sel, input int start, input int hold, output int l);
    l = 0;
    for (int n = start; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin href = 0; clken = 0; end
      if (n == hold) vsync = 0;
      if (sel ? sv1 : sv0) begin l = n; break; end
    end
  endtask
  initial begin
    #1 rst = 1;
    #1;
    chk_out(0, "reset", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    check("reset.valid", sv0, 0);
    check("reset.busy", busy0, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    do_edge(0, 0);
    wait_valid(0, 1, 1, lat);
    check("first_edge.nopulse", lat, 0);
    repeat (4) pix(8'h80);
    gap(2);
    repeat (4) pix(8'h80);
    gap(2);
    do_edge(0, 0);
    wait_valid(0, 1, 1, lat);
    check("flat.lat", lat, 29);
    chk_out(0, "flat", 8'h80, 8'h80, 8'h80, 3'd7, 1'b0);
    @(negedge clk);
    check("flat.single", sv0, 0);
    for (int i = 0; i < 255; i++) pix(i[7:0]);
    do_edge(1, 8'hFF);
    wait_valid(0, 1, 1, lat);
    check("ramp.lat", lat, 29);
    chk_out(0, "ramp", 8'h7F, 8'h00, 8'hFF, 3'd0, 1'b0);
    @(negedge clk);
    check("ramp.single", sv0, 0);
    do_edge(0, 0);
    wait_valid(0, 1, 5, lat);
    check("empty.lat", lat, 1);
    chk_out(0, "empty", 8'h00, 8'h00, 8'h00, 3'd7, 1'b1);
    wait_valid(0, 2, 5, lat);
    check("held_vsync.nopulse", lat, 0);
    repeat (4) pix(8'h20);
    do_edge(0, 0);
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) vsync = 0;
      href = i <= 8; clken = i <= 8; y = 8'h60;
      if (sv0) pulses++;
    end
    do_edge(0, 0);
    if (sv0) pulses++;
    check("abandon.nopulse", pulses, 0);
    wait_valid(0, 1, 1, lat);
    check("restart.lat", lat, 29);
    chk_out(0, "restart", 8'h60, 8'h60, 8'h60, 3'd7, 1'b0);
    wait_valid(0, lat + 1, 1, lat);
    check("restart.extra", lat, 0);
    repeat (20) pix(8'h10);
    pix(8'h90);
    do_edge(0, 0);
    wait_valid(1, 1, 1, lat);
    check("sat4.lat", lat, 13);
    chk_out(1, "sat4", 8'h10, 8'h10, 8'h90, 3'd3, 1'b0);
    wait_valid(0, lat + 1, 1, lat);
    check("sat20.lat", lat, 29);
    chk_out(0, "sat20", 8'h16, 8'h10, 8'h90, 3'd3, 1'b0);
    repeat (3) pix(8'hF0);
    do_edge(0, 0);
    @(negedge clk);
    vsync = 0; href = 0; clken = 0;
    check("rst.busy_pre", busy0, 1);
    repeat (2) pix(8'hF0);
    @(negedge clk);
    rst = 1; href = 0; clken = 0;
    #1;
    chk_out(0, "in_rst", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    check("in_rst.mean4", mean1, 0);
    check("in_rst.valid", sv0, 0);
    check("in_rst.busy", busy0, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) pix(8'hF0);
    do_edge(0, 0);
    wait_valid(0, 1, 1, lat);
    check("post_rst.first_nopulse", lat, 0);
    pix(8'h30); pix(8'h30); pix(8'h50); pix(8'h50);
    do_edge(0, 0);
    wait_valid(0, 1, 1, lat);
    check("post_rst.lat", lat, 29);
    chk_out(0, "post_rst", 8'h40, 8'h30, 8'h50, 3'd6, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
